alu_mul_seq: RTL

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

---
 rtl/alu_mul_seq_if.sv | 41 ++++
 rtl/alu_mul_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq_if.sv
// Shared constants and the start/result/ALU-port bundle for alu_mul_seq.
// ALU opcodes mirror the shared ALU's opcode map.
package alu_mul_seq_pkg;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned OPC_W  = 4;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned ITER   = 16;

   localparam logic [OPC_W-1:0] ALU_NOP   = 4'h0;
   localparam logic [OPC_W-1:0] ALU_ADD   = 4'h1;
   localparam logic [OPC_W-1:0] ALU_SHIFT = 4'h4;
endpackage

interface alu_mul_seq_if;
   import alu_mul_seq_pkg::*;

   logic              i_start;
   logic              i_abort;
   logic [DATA_W-1:0] i_a;
   logic [DATA_W-1:0] i_b;
   logic              o_busy;
   logic              o_valid;
   logic [DATA_W-1:0] o_result;
   logic [OPC_W-1:0]  o_alu_opcode;
   logic              o_alu_shift_dir;
   logic [DATA_W-1:0] o_alu_data1;
   logic [DATA_W-1:0] o_alu_data2;
   logic [DATA_W-1:0] i_alu_result;

   modport master (
      output i_start, i_abort, i_a, i_b, i_alu_result,
      input  o_busy, o_valid, o_result, o_alu_opcode, o_alu_shift_dir,
             o_alu_data1, o_alu_data2
   );

   modport slave (
      input  i_start, i_abort, i_a, i_b, i_alu_result,
      output o_busy, o_valid, o_result, o_alu_opcode, o_alu_shift_dir,
             o_alu_data1, o_alu_data2
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 (low half) shift-add multiplier driving a shared external ALU.
// Optional: ALU_MUL_SEQ_EARLY_EXIT_EN finishes as soon as the multiplier shifts to zero.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
(
   input logic          i_clk,
   input logic          i_rst_n,
   alu_mul_seq_if.slave bus
);

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_SHL,
      S_SHR,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [OPC_W-1:0]  opc_q, opc_d;
   logic              dir_q, dir_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   logic [DATA_W-1:0] data2_q, data2_d;

   // Next state and datapath; ALU drive is decoded from the next state so it is registered.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      result_d = result_q;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      opc_d    = ALU_NOP;
      dir_d    = 1'b0;
      data1_d  = '0;
      data2_d  = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               mcand_d  = bus.i_a;
               mplier_d = bus.i_b;
               acc_d    = '0;
               count_d  = '0;
               result_d = '0;
               state_d  = S_ADD;
            end
         end
         S_ADD: begin
            if (mplier_q[0]) acc_d = bus.i_alu_result;
            state_d = S_SHL;
         end
         S_SHL: begin
            mcand_d = bus.i_alu_result;
            state_d = S_SHR;
         end
         S_SHR: begin
            mplier_d = bus.i_alu_result;
            count_d  = count_q + CNT_W'(1);
            if ((count_d == CNT_W'(ITER)) ||
                (EARLY_EXIT && (bus.i_alu_result == '0))) begin
               result_d = acc_q;
               state_d  = S_DONE;
            end else begin
               state_d  = S_ADD;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort wins over every transition outside IDLE and leaves o_result alone.
      if ((state_q != S_IDLE) && bus.i_abort) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end

      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_DONE);
      case (state_d)
         S_ADD: begin
            opc_d   = ALU_ADD;
            data1_d = acc_d;
            data2_d = mcand_d;
         end
         S_SHL: begin
            opc_d   = ALU_SHIFT;
            dir_d   = 1'b1;
            data1_d = mcand_d;
            data2_d = DATA_W'(1);
         end
         S_SHR: begin
            opc_d   = ALU_SHIFT;
            dir_d   = 1'b0;
            data1_d = mplier_d;
            data2_d = DATA_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         opc_q    <= ALU_NOP;
         dir_q    <= 1'b0;
         data1_q  <= '0;
         data2_q  <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         opc_q    <= opc_d;
         dir_q    <= dir_d;
         data1_q  <= data1_d;
         data2_q  <= data2_d;
      end
   end

   assign bus.o_busy          = busy_q;
   assign bus.o_valid         = valid_q;
   assign bus.o_result        = result_q;
   assign bus.o_alu_opcode    = opc_q;
   assign bus.o_alu_shift_dir = dir_q;
   assign bus.o_alu_data1     = data1_q;
   assign bus.o_alu_data2     = data2_q;

endmodule
